// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Sequencer and arbiter for the single shared memory port between
// instruction fetch (IF) and the data stage (D). One access at a time:
// IDLE arbitrates, ISSUE holds a registered request on the memory port
// until mem_ready or a timeout, and RESP pulses the owner's ack for one cycle.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch read request (held until if_ack)
//   if_rdata/if_ack               fetch read data and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata     data request (held until d_ack)
//   d_rdata/d_ack                 data read data and one-cycle completion pulse
//   stall_mem_ready, stall_fetch  combinational pipeline stalls
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_rdata/mem_ready           memory response
//   mem_err                       sticky timeout flag, cleared only by rst
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ack,
  output logic        stall_mem_ready,
  output logic        stall_fetch,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [3:0]  starve_q, starve_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        mem_err_q, mem_err_d;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    tmo_d       = tmo_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_err_d   = mem_err_q;

    case (state_q)
      ST_IDLE: begin
        // D wins unless IF has already been passed over STARVE_LIMIT times.
        if (d_req && (!if_req || (starve_q < STARVE_MAX))) begin
          owner_d     = OWN_D;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          starve_d    = if_req ? (starve_q + 4'd1) : 4'd0;
          mem_req_d   = 1'b1;
          tmo_d       = 8'd0;
          state_d     = ST_ISSUE;
        end else if (if_req) begin
          // mem_wdata is left as-is for fetches; only the write enable matters.
          owner_d    = OWN_IF;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          starve_d   = 4'd0;
          mem_req_d  = 1'b1;
          tmo_d      = 8'd0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A response in the expiry cycle still completes normally.
        if (mem_ready) begin
          if (owner_q == OWN_D) d_rdata_d = mem_rdata;
          else                  if_rdata_d = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
        end else if (tmo_q == TMO_LAST) begin
          if (owner_q == OWN_D) d_rdata_d = 16'hFFFF;
          else                  if_rdata_d = 16'hFFFF;
          mem_req_d = 1'b0;
          mem_err_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      tmo_q       <= 8'd0;
      starve_q    <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 16'd0;
      if_rdata_q  <= 16'd0;
      d_rdata_q   <= 16'd0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      tmo_q       <= tmo_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // Acks are decoded from the RESP state, so they last exactly one cycle.
  assign if_ack          = (state_q == ST_RESP) && (owner_q == OWN_IF);
  assign d_ack           = (state_q == ST_RESP) && (owner_q == OWN_D);
  assign if_rdata        = if_rdata_q;
  assign d_rdata         = d_rdata_q;
  assign stall_mem_ready = d_req & ~d_ack;
  assign stall_fetch     = if_req & ~if_ack;
  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_err         = mem_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int TMO    = 8;
  localparam int STARVE = 4;

  logic        clk, rst;
  logic        if_req, d_req, d_we, mem_ready;
  logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, stall_mem_ready, stall_fetch;
  logic        mem_req, mem_we, mem_err;

  int          tests = 0;
  int          fails = 0;

  // Transaction-level reference state
  int          m_starve;
  logic        exp_err;
  logic [15:0] exp_if_rdata, exp_d_rdata, exp_wdata;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TMO), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .stall_mem_ready(stall_mem_ready), .stall_fetch(stall_fetch),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    tick();
    chk("rst_mem_req", {15'd0, mem_req}, 16'd0);
    chk("rst_mem_we", {15'd0, mem_we}, 16'd0);
    chk("rst_mem_addr", mem_addr, 16'd0);
    chk("rst_mem_wdata", mem_wdata, 16'd0);
    chk("rst_if_rdata", if_rdata, 16'd0);
    chk("rst_d_rdata", d_rdata, 16'd0);
    chk("rst_acks", {14'd0, if_ack, d_ack}, 16'd0);
    chk("rst_mem_err", {15'd0, mem_err}, 16'd0);
    rst = 1'b0;
    m_starve = 0; exp_err = 1'b0;
    exp_if_rdata = 16'd0; exp_d_rdata = 16'd0; exp_wdata = 16'd0;
    $display("[TB] reset applied");
  endtask

  // Runs one access starting in an IDLE cycle with requests already driven.
  // w = number of ISSUE cycles before mem_ready (w >= TMO means never).
  // Ends in the following IDLE cycle; returns the observed d_ack at RESP.
  task automatic do_txn(input int w, input logic [15:0] rd, output logic obs_d);
    logic        own_d;
    logic [15:0] ea, res;
    logic        ewe;
    own_d = d_req && (!if_req || m_starve < STARVE);
    if (own_d) begin
      m_starve  = if_req ? m_starve + 1 : 0;
      ea        = d_addr;
      ewe       = d_we;
      exp_wdata = d_wdata;
    end else begin
      m_starve = 0;
      ea       = if_addr;
      ewe      = 1'b0;
    end
    mem_ready = 1'($urandom);
    mem_rdata = 16'($urandom);
    #1;
    chk("idle_mem_req", {15'd0, mem_req}, 16'd0);
    chk("idle_acks", {14'd0, if_ack, d_ack}, 16'd0);
    chk("idle_stall_mem", {15'd0, stall_mem_ready}, {15'd0, d_req});
    chk("idle_stall_fetch", {15'd0, stall_fetch}, {15'd0, if_req});
    tick();
    for (int i = 0; i < TMO; i++) begin
      chk("issue_mem_req", {15'd0, mem_req}, 16'd1);
      chk("issue_mem_addr", mem_addr, ea);
      chk("issue_mem_we", {15'd0, mem_we}, {15'd0, ewe});
      chk("issue_mem_wdata", mem_wdata, exp_wdata);
      chk("issue_acks", {14'd0, if_ack, d_ack}, 16'd0);
      chk("issue_stall_mem", {15'd0, stall_mem_ready}, {15'd0, d_req});
      mem_ready = (i == w);
      mem_rdata = (i == w) ? rd : 16'($urandom);
      tick();
      if (i == w) break;
    end
    res = (w >= TMO) ? 16'hFFFF : rd;
    if (w >= TMO) exp_err = 1'b1;
    if (own_d) exp_d_rdata = res;
    else       exp_if_rdata = res;
    mem_ready = 1'($urandom);
    #1;
    obs_d = d_ack;
    chk("resp_d_ack", {15'd0, d_ack}, {15'd0, own_d});
    chk("resp_if_ack", {15'd0, if_ack}, {15'd0, ~own_d});
    chk("resp_d_rdata", d_rdata, exp_d_rdata);
    chk("resp_if_rdata", if_rdata, exp_if_rdata);
    chk("resp_mem_req", {15'd0, mem_req}, 16'd0);
    chk("resp_mem_err", {15'd0, mem_err}, {15'd0, exp_err});
    chk("resp_stall_mem", {15'd0, stall_mem_ready}, {15'd0, d_req & ~own_d});
    chk("resp_stall_fetch", {15'd0, stall_fetch}, {15'd0, if_req & own_d});
    $display("[TB] txn owner=%s addr=%h we=%0d wait=%0d rdata=%h err=%0d",
             own_d ? "D" : "IF", ea, ewe, w, res, exp_err);
    tick();
  endtask

  logic       obs_d;
  logic [9:0] order_tbl;

  initial begin
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    if_addr = 16'd0; d_addr = 16'd0; d_wdata = 16'd0; mem_rdata = 16'd0;
    tick();
    do_reset();

    // D read alone, immediate response
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100; d_wdata = 16'h0;
    do_txn(0, 16'h1234, obs_d);
    d_req = 1'b0;

    // Both requesters held continuously: D,D,D,D,IF repeating
    do_reset();
    order_tbl = 10'b1111011110;
    if_req = 1'b1; if_addr = 16'h0A00;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0B00;
    for (int g = 0; g < 10; g++) begin
      do_txn(0, 16'($urandom), obs_d);
      chk("grant_order", {15'd0, obs_d}, {15'd0, order_tbl[9-g]});
    end
    if_req = 1'b0; d_req = 1'b0;

    // D write with mem_ready delayed 3 cycles
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
    do_txn(3, 16'h7777, obs_d);
    d_req = 1'b0; d_we = 1'b0;

    // Reset during the second ISSUE cycle of a D read
    d_req = 1'b1; d_addr = 16'h0200; mem_ready = 1'b0;
    tick();
    chk("pre_rst_mem_req", {15'd0, mem_req}, 16'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_mem_req", {15'd0, mem_req}, 16'd0);
    chk("abort_d_ack", {15'd0, d_ack}, 16'd0);
    m_starve = 0; exp_err = 1'b0;
    exp_if_rdata = 16'd0; exp_d_rdata = 16'd0; exp_wdata = 16'd0;
    $display("[TB] reset during ISSUE, D request reissued");
    do_txn(0, 16'h5A5A, obs_d);
    d_req = 1'b0;

    // IF read that times out
    if_req = 1'b1; if_addr = 16'h0300;
    do_txn(TMO + 4, 16'h0000, obs_d);
    if_req = 1'b0;
    tick();
    chk("err_sticky", {15'd0, mem_err}, 16'd1);

    // Randomised traffic against the transaction-level model
    for (int k = 0; k < 80; k++) begin
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1'b1; if_addr = 16'($urandom);
      end
      if (!d_req && $urandom_range(0, 1) == 1) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      if (!if_req && !d_req) begin
        mem_ready = 1'($urandom);
        #1;
        chk("rand_idle_mem_req", {15'd0, mem_req}, 16'd0);
        chk("rand_idle_err", {15'd0, mem_err}, {15'd0, exp_err});
        tick();
      end else begin
        do_txn($urandom_range(0, TMO + 1), 16'($urandom), obs_d);
        if (obs_d) d_req = 1'b0;
        else       if_req = 1'b0;
      end
    end

    // Reset clears the sticky error
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
